// File: rtl/game_pkg.sv
// Shared types and default constants for the game level controller.
// Widths are fixed by the renderer and obstacle-counter interfaces.
package game_pkg;

  typedef enum logic [1:0] {
    MENU = 2'd0,
    PLAY = 2'd1,
    WON  = 2'd2,
    LOST = 2'd3
  } state_e;

  localparam int TIME_W      = 11;
  localparam int POS_W       = 10;
  localparam int PHASE_LEN   = 300;
  localparam int WIN_TIME    = 1200;
  localparam int HOLD_CYCLES = 120;

endpackage

// File: rtl/rise_edge_detect.sv
// Registered rising-edge detector. After reset it stays disarmed until the
// input has been seen low, so a level held through reset never fires.
module rise_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig_i,
  output logic pulse_o
);

  logic prev_q;
  logic armed_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= sig_i;
      armed_q <= armed_q | ~sig_i;
    end
  end

  assign pulse_o = sig_i & ~prev_q & armed_q;

endmodule

// File: rtl/game_level_controller.sv
// Top-level game flow FSM: MENU -> PLAY -> WON/LOST -> MENU, with level
// phase tracking and obstacle-restart pulses during PLAY.
module game_level_controller
  import game_pkg::*;
#(
  parameter int PHASE_LEN   = game_pkg::PHASE_LEN,
  parameter int WIN_TIME    = game_pkg::WIN_TIME,
  parameter int HOLD_CYCLES = game_pkg::HOLD_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_btn,
  input  logic              collision,
  input  logic [TIME_W-1:0] game_time,
  input  logic [POS_W-1:0]  obj_position_counter,
  output logic              menu_screen,
  output logic              player_won,
  output logic              player_lost,
  output logic              reset_obj_count,
  output logic [1:0]        level_phase
);

  if (!((PHASE_LEN * 3 < WIN_TIME) && (WIN_TIME <= 2047) &&
        (HOLD_CYCLES >= 1) && (HOLD_CYCLES <= 256))) begin : g_param_check
    $error("game_level_controller: illegal PHASE_LEN/WIN_TIME/HOLD_CYCLES");
  end

  localparam logic [TIME_W-1:0] TH1       = TIME_W'(PHASE_LEN);
  localparam logic [TIME_W-1:0] TH2       = TIME_W'(PHASE_LEN * 2);
  localparam logic [TIME_W-1:0] TH3       = TIME_W'(PHASE_LEN * 3);
  localparam logic [TIME_W-1:0] WIN_T     = TIME_W'(WIN_TIME);
  localparam logic [7:0]        HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_e            state_q, state_d;
  logic [1:0]        phase_q, phase_d;
  logic [7:0]        hold_q, hold_d;
  logic              roc_q, roc_d;
  logic              start_pulse;
  logic [TIME_W-1:0] thr;
  logic              unused_pos;

  // Obstacle position is observed for debug only.
  assign unused_pos = ^obj_position_counter;

  rise_edge_detect u_start_edge (
    .clk     (clk),
    .reset   (reset),
    .sig_i   (start_btn),
    .pulse_o (start_pulse)
  );

  always_comb begin
    case (phase_q)
      2'd0:    thr = TH1;
      2'd1:    thr = TH2;
      default: thr = TH3;
    endcase
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    hold_d  = hold_q;
    roc_d   = 1'b0;
    case (state_q)
      MENU: begin
        if (start_pulse) state_d = PLAY;
      end
      PLAY: begin
        // Collision outranks the win check; phase steps only when staying in PLAY.
        if (collision) begin
          state_d = LOST;
        end else if (game_time >= WIN_T) begin
          state_d = WON;
        end else if ((phase_q != 2'd3) && (game_time == thr)) begin
          phase_d = 2'(phase_q + 2'd1);
          roc_d   = 1'b1;
        end
      end
      WON, LOST: begin
        if (start_pulse || (hold_q == HOLD_LAST)) begin
          state_d = MENU;
        end else begin
          hold_d = 8'(hold_q + 8'd1);
        end
      end
      default: state_d = MENU;
    endcase
    if (state_d != state_q) hold_d = 8'd0;
    if (state_d == MENU) phase_d = 2'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MENU;
      phase_q <= 2'd0;
      hold_q  <= 8'd0;
      roc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      hold_q  <= hold_d;
      roc_q   <= roc_d;
    end
  end

  assign menu_screen     = (state_q == MENU);
  assign player_won      = (state_q == WON);
  assign player_lost     = (state_q == LOST);
  assign reset_obj_count = roc_q;
  assign level_phase     = phase_q;

endmodule

// File: tb/tb_game_level_controller.sv
// Scoreboard bench for game_level_controller: stimulus queues the expected
// output vector and its cycle, a monitor checks every output change.
module tb_game_level_controller;
  import game_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              start_btn;
  logic              collision;
  logic [TIME_W-1:0] game_time;
  logic [POS_W-1:0]  obj_position_counter;
  logic              menu_screen, player_won, player_lost, reset_obj_count;
  logic [1:0]        level_phase;

  game_level_controller dut (
    .clk                  (clk),
    .reset                (reset),
    .start_btn            (start_btn),
    .collision            (collision),
    .game_time            (game_time),
    .obj_position_counter (obj_position_counter),
    .menu_screen          (menu_screen),
    .player_won           (player_won),
    .player_lost          (player_lost),
    .reset_obj_count      (reset_obj_count),
    .level_phase          (level_phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [5:0] vec;
  } exp_t;

  exp_t       sbq[$];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  bit         mon_en = 1'b0;
  logic [5:0] prev;

  // {menu, won, lost, reset_obj_count, level_phase}
  localparam logic [5:0] V_MENU = 6'b100000;

  function automatic logic [5:0] outvec();
    return {menu_screen, player_won, player_lost, reset_obj_count, level_phase};
  endfunction

  function automatic logic [5:0] v_play(input logic [1:0] ph, input logic roc);
    return {3'b000, roc, ph};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [5:0] cur;
    exp_t       e;
    if (mon_en) begin
      cur = outvec();
      if (cur !== prev) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_change cyc=%0d got=%b want=no change", cyc, cur);
        end else begin
          e = sbq.pop_front();
          if ((e.vec !== cur) || (e.cyc != cyc)) begin
            bad++;
            $display("FAIL out_change got=%b@%0d want=%b@%0d", cur, cyc, e.vec, e.cyc);
          end
        end
        prev = cur;
      end else if ((sbq.size() > 0) && (sbq[0].cyc < cyc)) begin
        total++;
        bad++;
        e = sbq.pop_front();
        $display("FAIL missed_change got=%b@%0d want=%b@%0d", cur, cyc, e.vec, e.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_chg(input int d, input logic [5:0] v);
    exp_t e;
    e.cyc = cyc + d;
    e.vec = v;
    sbq.push_back(e);
  endtask

  task automatic press_start();
    start_btn = 1'b1;
    exp_chg(1, v_play(2'd0, 1'b0));
    step();
    start_btn = 1'b0;
    step();
  endtask

  // Sweeps game_time from 0 to last, expecting a phase pulse at each threshold.
  task automatic sweep(input int last, input int coll_at);
    logic [1:0] ph;
    ph = 2'd0;
    for (int t = 0; t <= last; t++) begin
      game_time = 11'(t);
      collision = (t == coll_at);
      if (t == coll_at) begin
        exp_chg(1, {3'b001, 1'b0, ph});
        exp_chg(1 + 120, V_MENU);
      end else if (t >= 1200) begin
        exp_chg(1, {3'b010, 1'b0, ph});
      end else if ((t == 300) || (t == 600) || (t == 900)) begin
        ph = 2'(ph + 2'd1);
        exp_chg(1, v_play(ph, 1'b1));
        exp_chg(2, v_play(ph, 1'b0));
      end
      step();
    end
    collision = 1'b0;
    game_time = '0;
  endtask

  initial begin
    reset = 1'b1;
    start_btn = 1'b0;
    collision = 1'b0;
    game_time = '0;
    obj_position_counter = 10'd123;
    repeat (3) step();
    reset = 1'b0;
    step();

    total++;
    if (outvec() !== V_MENU) begin
      bad++;
      $display("FAIL reset_state got=%b want=%b", outvec(), V_MENU);
    end
    prev = outvec();
    mon_en = 1'b1;

    // Start, then hold the button: no retrigger.
    start_btn = 1'b1;
    exp_chg(1, v_play(2'd0, 1'b0));
    repeat (50) step();
    start_btn = 1'b0;
    step();

    // Survive to the win time; WON entered one cycle after the last sweep value.
    sweep(1200, -1);
    repeat (10) step();
    start_btn = 1'b1;
    exp_chg(1, V_MENU);
    step();
    start_btn = 1'b0;
    step();
    press_start();

    // Collision at 450: LOST with phase 1, auto-return after the hold.
    sweep(450, 450);
    repeat (125) step();

    // Collision coincides with the win time: collision wins.
    press_start();
    sweep(1200, 1200);
    repeat (125) step();

    // Async reset mid-PLAY at phase 2 with start held through reset.
    press_start();
    sweep(600, -1);
    repeat (3) step();
    start_btn = 1'b1;
    step();
    #2;
    reset = 1'b1;
    exp_chg(0, V_MENU);
    step();
    step();
    reset = 1'b0;
    repeat (5) step();
    start_btn = 1'b0;
    step();
    start_btn = 1'b1;
    exp_chg(1, v_play(2'd0, 1'b0));
    step();
    start_btn = 1'b0;
    repeat (3) step();

    mon_en = 1'b0;
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL pending_expect got=%0d want=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_level_controller.md
GAME_LEVEL_CONTROLLER -- requirements
Module: game_level_controller

Interface
REQ-001 Parameter PHASE_LEN, default 300, game_time ticks per level phase.
REQ-002 Parameter WIN_TIME, default 1200, game_time value at which a surviving player wins.
REQ-003 Parameter HOLD_CYCLES, default 120, clk cycles the WON/LOST screen is held before returning to MENU.
REQ-004 clk  input  1  system clock, all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start_btn  input  1  debounced start button, level-sensitive, synchronous to clk.
REQ-007 collision  input  1  player/obstacle overlap flag from the renderer.
REQ-008 game_time  input  11  level time from the obstacle counter block.
REQ-009 obj_position_counter  input  10  obstacle offset, monitoring only; it does not affect control decisions.
REQ-010 menu_screen  output  1  high while in MENU.
REQ-011 player_won  output  1  high while in WON.
REQ-012 player_lost  output  1  high while in LOST.
REQ-013 reset_obj_count  output  1  one-cycle pulse restarting obstacle motion at each phase change.
REQ-014 level_phase  output  2  current phase 0..3 within PLAY.

Function
REQ-015 FSM states: MENU, PLAY, WON, LOST; all outputs are registered and change one cycle after the causing input.
REQ-016 MENU->PLAY on start_btn rising edge (start_btn high this cycle, low the previous cycle); holding the button does not retrigger.
REQ-017 In PLAY, collision==1 -> LOST next cycle.
REQ-018 In PLAY, game_time >= WIN_TIME with collision==0 -> WON next cycle.
REQ-019 Collision and win condition in the same cycle -> LOST (collision priority).
REQ-020 WON/LOST: 8-bit hold counter cleared on entry, increments every cycle; state returns to MENU in the cycle after the counter reaches HOLD_CYCLES-1.
REQ-021 start_btn rising edge in WON/LOST -> MENU immediately (next cycle), aborting the hold.
REQ-022 level_phase = 0 on PLAY entry; in PLAY, when game_time == PHASE_LEN*(level_phase+1) and level_phase<3, level_phase increments and reset_obj_count pulses high for exactly one cycle.
REQ-023 level_phase saturates at 3 with no further reset_obj_count pulses; it holds its value in WON/LOST and clears to 0 in MENU.
REQ-024 reset_obj_count is never asserted outside PLAY, and never in the same cycle as a PLAY->LOST/WON transition output.
REQ-025 menu_screen, player_won and player_lost are mutually exclusive, and exactly one is high outside PLAY.
REQ-026 Phase-threshold products are computed at 11-bit width; PHASE_LEN*3 < WIN_TIME <= 2047 is a legal-parameter requirement, checked by an elaboration-time assertion.

Reset
REQ-027 Reset forces MENU: menu_screen=1, player_won=0, player_lost=0, reset_obj_count=0, level_phase=0, hold counter=0, start edge register=0.
REQ-028 Reset asserted mid-PLAY or mid-hold takes effect immediately (asynchronously) and overrides all other events.
REQ-029 After reset deasserts, a start_btn already held high does not start the game until it is released and pressed again.

Structure
REQ-030 Shared package game_pkg holds the state enum (MENU, PLAY, WON, LOST) and default constants PHASE_LEN, WIN_TIME, HOLD_CYCLES, plus the widths TIME_W=11 and POS_W=10.
REQ-031 One sub-module, rise_edge_detect (1-bit registered rising-edge detector), produces the start pulse; everything else is in a single FSM module.

Verification
REQ-032 Reset, then start_btn 0->1 -> menu_screen=0 one cycle later, level_phase=0; holding start_btn for 50 cycles causes no further transitions.
REQ-033 PLAY with game_time driven 0..1199 and no collision -> reset_obj_count pulses at game_time 300, 600, 900 only; level_phase=1,2,3; player_won=1 one cycle after game_time=1200.
REQ-034 PLAY, collision=1 at game_time=450 -> player_lost=1 next cycle, level_phase holds at 1; MENU after 120 cycles with menu_screen=1 and level_phase=0.
REQ-035 collision=1 in the same cycle that game_time=1200 -> player_lost=1, player_won stays 0.
REQ-036 In WON, start_btn edge at hold count 10 -> menu_screen=1 next cycle; in MENU, a second edge starts a new PLAY.
REQ-037 Reset pulse mid-PLAY at level_phase=2 -> outputs immediately return to REQ-027 values; start_btn held through reset does not start play.
